// File: rtl/cmp_32_pkg.sv
// Shared core package: branch condition codes and
// the merge rule for the comparator slice tree.
package cmp_32_pkg;

    typedef enum logic [3:0] {
        CMP_NONE = 4'b0000,
        CMP_EQ   = 4'b0001,
        CMP_NE   = 4'b0010,
        CMP_LT   = 4'b0011,
        CMP_LTU  = 4'b0100,
        CMP_GE   = 4'b0101,
        CMP_GEU  = 4'b0110
    } cmp_op_e;

    typedef struct packed {
        logic lt;
        logic eq;
    } mag_t;

    // Upper half decides unless it is equal.
    function automatic mag_t mag_merge(mag_t hi, mag_t lo);
        mag_t r;
        r.lt = hi.lt | (hi.eq & lo.lt);
        r.eq = hi.eq & lo.eq;
        return r;
    endfunction

endpackage

// File: rtl/cmp_32_mag32.sv
// Unsigned 32-bit less-than / equal unit built as
// a three-level tree over eight 4-bit slices.
module cmp_mag32
    import cmp_32_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        lt,
    output logic        eq
);

    mag_t w_l0 [8];
    mag_t w_l1 [4];
    mag_t w_l2 [2];
    mag_t w_l3;

    for (genvar g = 0; g < 8; g++) begin : g_slice
        assign w_l0[g].lt = a[4*g +: 4] < b[4*g +: 4];
        assign w_l0[g].eq = a[4*g +: 4] == b[4*g +: 4];
    end

    for (genvar g = 0; g < 4; g++) begin : g_lvl1
        assign w_l1[g] = mag_merge(w_l0[2*g+1], w_l0[2*g]);
    end

    for (genvar g = 0; g < 2; g++) begin : g_lvl2
        assign w_l2[g] = mag_merge(w_l1[2*g+1], w_l1[2*g]);
    end

    assign w_l3 = mag_merge(w_l2[1], w_l2[0]);
    assign lt   = w_l3.lt;
    assign eq   = w_l3.eq;

endmodule

// File: rtl/cmp_32.sv
// Branch-condition comparator: combinational take bit
// plus a registered copy for pipeline observation.
module cmp_32
    import cmp_32_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  ctrl,
    output logic        c,
    output logic        c_q
);

    logic w_ult;
    logic w_eq;
    logic w_slt;
    logic w_c;
    logic r_c_q;

    cmp_mag32 u_mag (
        .a  (a),
        .b  (b),
        .lt (w_ult),
        .eq (w_eq)
    );

    // Mixed signs: the operand with bit 31 set is smaller.
    assign w_slt = (a[31] ^ b[31]) ? a[31] : w_ult;

    always_comb begin
        w_c = 1'b0;
        case (ctrl)
            CMP_EQ:  w_c = w_eq;
            CMP_NE:  w_c = ~w_eq;
            CMP_LT:  w_c = w_slt;
            CMP_LTU: w_c = w_ult;
            CMP_GE:  w_c = ~w_slt;
            CMP_GEU: w_c = ~w_ult;
            default: w_c = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_c_q <= 1'b0;
        else        r_c_q <= w_c;
    end

    assign c   = w_c;
    assign c_q = r_c_q;

endmodule

// File: tb/tb_cmp_32.sv
// Directed and random checks of cmp_32 against a
// reference model built on plain signed/unsigned compares.
module tb_cmp_32;

    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic        c;
    logic        c_q;

    int checks;
    int errors;

    cmp_32 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .ctrl  (ctrl),
        .c     (c),
        .c_q   (c_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic ref_c(
        input logic [31:0] x,
        input logic [31:0] y,
        input logic [3:0]  op
    );
        case (op)
            4'd1:    return x == y;
            4'd2:    return x != y;
            4'd3:    return $signed(x) < $signed(y);
            4'd4:    return x < y;
            4'd5:    return $signed(x) >= $signed(y);
            4'd6:    return x >= y;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b a=%h b=%h ctrl=%b",
                   tag, obs, exp, a, b, ctrl);
        end
    endtask

    task automatic drive_c(input logic [31:0] x, input logic [31:0] y,
                           input logic [3:0] op, input logic exp,
                           input string tag);
        a = x;
        b = y;
        ctrl = op;
        #1;
        check(tag, c, exp);
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] corners [5];
        corners[0] = 32'h0000_0000;
        corners[1] = 32'h0000_0001;
        corners[2] = 32'h7FFF_FFFF;
        corners[3] = 32'h8000_0000;
        corners[4] = 32'hFFFF_FFFF;
        if ($urandom_range(0, 1) == 0)
            return corners[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [3:0]  rc;
        logic        exp;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        a = '0;
        b = '0;
        ctrl = 4'b0000;
        #1;
        check("reset_cq", c_q, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;

        // EQ / NE
        drive_c(32'h1234_5678, 32'h1234_5678, 4'b0001, 1'b1, "eq_same");
        drive_c(32'h1234_5678, 32'h1234_5678, 4'b0010, 1'b0, "ne_same");
        drive_c(32'h1234_5678, 32'h1234_5679, 4'b0001, 1'b0, "eq_diff");
        drive_c(32'h1234_5678, 32'h1234_5679, 4'b0010, 1'b1, "ne_diff");

        // Signed vs unsigned
        drive_c(32'hFFFF_FFFF, 32'h0000_0001, 4'b0011, 1'b1, "lt_m1_1");
        drive_c(32'hFFFF_FFFF, 32'h0000_0001, 4'b0100, 1'b0, "ltu_m1_1");
        drive_c(32'hFFFF_FFFF, 32'h0000_0001, 4'b0101, 1'b0, "ge_m1_1");
        drive_c(32'hFFFF_FFFF, 32'h0000_0001, 4'b0110, 1'b1, "geu_m1_1");

        // Extremes
        drive_c(32'h8000_0000, 32'h7FFF_FFFF, 4'b0011, 1'b1, "lt_min_max");
        drive_c(32'h8000_0000, 32'h7FFF_FFFF, 4'b0100, 1'b0, "ltu_min_max");
        drive_c(32'h7FFF_FFFF, 32'h8000_0000, 4'b0011, 1'b0, "lt_max_min");
        drive_c(32'h7FFF_FFFF, 32'h8000_0000, 4'b0101, 1'b1, "ge_max_min");
        drive_c(32'h8000_0000, 32'h8000_0000, 4'b0101, 1'b1, "ge_min_min");
        drive_c(32'h8000_0000, 32'h8000_0000, 4'b0110, 1'b1, "geu_min_min");
        drive_c(32'h8000_0000, 32'h8000_0000, 4'b0011, 1'b0, "lt_min_min");

        // NONE / reserved
        drive_c(32'h0, 32'h0, 4'b0000, 1'b0, "none");
        drive_c(32'h0, 32'h0, 4'b0111, 1'b0, "rsv_0111");
        drive_c(32'h0, 32'h0, 4'b1000, 1'b0, "rsv_1000");
        drive_c(32'h0, 32'h0, 4'b1111, 1'b0, "rsv_1111");

        // Register and asynchronous reset
        @(negedge clk);
        drive_c(32'd5, 32'd5, 4'b0001, 1'b1, "eq5");
        @(posedge clk);
        #1;
        check("cq_eq5", c_q, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("cq_async_rst", c_q, 1'b0);
        check("c_in_rst", c, 1'b1);
        @(posedge clk);
        #1;
        check("cq_hold_rst", c_q, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("cq_before_edge", c_q, 1'b0);
        @(posedge clk);
        #1;
        check("cq_after_release", c_q, 1'b1);
        @(negedge clk);
        drive_c(32'd5, 32'd5, 4'b0010, 1'b0, "ne5");
        check("cq_not_yet", c_q, 1'b1);
        @(posedge clk);
        #1;
        check("cq_ne5", c_q, 1'b0);

        // Random with corner values mixed in
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            ra = pick();
            rb = ($urandom_range(0, 7) == 0) ? ra : pick();
            rc = 4'($urandom_range(0, 15));
            exp = ref_c(ra, rb, rc);
            drive_c(ra, rb, rc, exp, "rand_c");
            @(posedge clk);
            #1;
            check("rand_cq", c_q, exp);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
